glyph_plotter: RTL

//   Datapath and sequencer that turns a letter code plus a screen origin into VGA-adapter pixel writes.

---
 rtl/glyph_pkg.sv | 24 ++
 rtl/glyph_plotter_if.sv | 25 ++
 rtl/glyph_rom.sv | 42 ++++
 rtl/glyph_plotter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// Shared constants and types for the glyph plotter: letter codes, screen defaults, FSM states.
package glyph_pkg;

  localparam int unsigned GLYPH_DIM     = 4;
  localparam int unsigned DEF_SCREEN_W  = 160;
  localparam int unsigned DEF_SCREEN_H  = 120;
  localparam logic [2:0]  DEF_BG_COLOUR = 3'b000;

  localparam logic [4:0] LTR_A = 5'd1,  LTR_B = 5'd2,  LTR_C = 5'd3,  LTR_D = 5'd4;
  localparam logic [4:0] LTR_E = 5'd5,  LTR_F = 5'd6,  LTR_G = 5'd7,  LTR_H = 5'd8;
  localparam logic [4:0] LTR_I = 5'd9,  LTR_J = 5'd10, LTR_K = 5'd11, LTR_L = 5'd12;
  localparam logic [4:0] LTR_M = 5'd13, LTR_N = 5'd14, LTR_O = 5'd15, LTR_P = 5'd16;
  localparam logic [4:0] LTR_Q = 5'd17, LTR_R = 5'd18, LTR_S = 5'd19, LTR_T = 5'd20;
  localparam logic [4:0] LTR_U = 5'd21, LTR_V = 5'd22, LTR_W = 5'd23, LTR_X = 5'd24;
  localparam logic [4:0] LTR_Y = 5'd25, LTR_Z = 5'd26;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StClear,
    StDone
  } state_e;

endpackage

// File: rtl/glyph_plotter_if.sv
// Request/pixel bus between the drawing controller (master) and the glyph plotter (slave).
interface glyph_plotter_if;
  logic       start;
  logic       clear_req;
  logic [4:0] letter;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [2:0] fg_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output start, clear_req, letter, x0, y0, fg_colour,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, clear_req, letter, x0, y0, fg_colour,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/glyph_rom.sv
// 4x4 glyph table: bit idx = row*4 + col, bit 0 is the top-left cell; invalid codes give 0.
module glyph_rom
  import glyph_pkg::*;
(
  input  logic [4:0]  letter_i,
  output logic [15:0] glyph_o
);

  always_comb begin
    glyph_o = 16'h0000;
    case (letter_i)
      LTR_A: glyph_o = 16'h9F96;
      LTR_B: glyph_o = 16'h7977;
      LTR_C: glyph_o = 16'hE11E;
      LTR_D: glyph_o = 16'h7997;
      LTR_E: glyph_o = 16'hF17F;
      LTR_F: glyph_o = 16'h117F;
      LTR_G: glyph_o = 16'hE91E;
      LTR_H: glyph_o = 16'h99F9;
      LTR_I: glyph_o = 16'h7227;
      LTR_J: glyph_o = 16'h6988;
      LTR_K: glyph_o = 16'h9579;
      LTR_L: glyph_o = 16'hF111;
      LTR_M: glyph_o = 16'h9FF9;
      LTR_N: glyph_o = 16'h9DB9;
      LTR_O: glyph_o = 16'hF99F;
      LTR_P: glyph_o = 16'h1797;
      LTR_Q: glyph_o = 16'hA596;
      LTR_R: glyph_o = 16'h9797;
      LTR_S: glyph_o = 16'h7C3E;
      LTR_T: glyph_o = 16'h222F;
      LTR_U: glyph_o = 16'h6999;
      LTR_V: glyph_o = 16'h4A99;
      LTR_W: glyph_o = 16'h6F99;
      LTR_X: glyph_o = 16'h9669;
      LTR_Y: glyph_o = 16'h2269;
      LTR_Z: glyph_o = 16'hF24F;
      default: glyph_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/glyph_plotter.sv
// Glyph plotter: draws 4x4 letter glyphs or sweeps the screen clear, one pixel per clock.
// Build option `GLYPH_BG_EN: unset glyph cells are also plotted in the background colour.
module glyph_plotter
  import glyph_pkg::*;
#(
  parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H  = DEF_SCREEN_H,
  parameter logic [2:0]  BG_COLOUR = DEF_BG_COLOUR
) (
  input logic            clk,
  input logic            reset,
  glyph_plotter_if.slave bus
);

  localparam logic [8:0]  XLimit    = 9'(SCREEN_W);
  localparam logic [7:0]  YLimit    = 8'(SCREEN_H);
  localparam logic [7:0]  SxLast    = 8'(SCREEN_W - 1);
  localparam logic [14:0] SweepLast = 15'(SCREEN_W * SCREEN_H - 1);
  localparam logic [3:0]  IdxLast   = 4'(GLYPH_DIM * GLYPH_DIM - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [14:0] sweep_q, sweep_d;
  logic [7:0]  sx_q, sx_d;
  logic [6:0]  sy_q, sy_d;
  logic [4:0]  letter_q, letter_d;
  logic [7:0]  x0_q, x0_d;
  logic [6:0]  y0_q, y0_d;
  logic [2:0]  fg_q, fg_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [15:0] glyph;
  logic [8:0]  cell_x;
  logic [7:0]  cell_y;
  logic        cell_in;
  logic        cell_set;

  glyph_rom u_rom (
    .letter_i (letter_q),
    .glyph_o  (glyph)
  );

  // One bit of headroom so cells past the right/bottom edge are clipped, not wrapped.
  always_comb begin
    cell_x   = {1'b0, x0_q} + {7'd0, idx_q[1:0]};
    cell_y   = {1'b0, y0_q} + {6'd0, idx_q[3:2]};
    cell_in  = (cell_x < XLimit) && (cell_y < YLimit);
    cell_set = glyph[idx_q];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sweep_d  = sweep_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    letter_d = letter_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    fg_d     = fg_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.clear_req) begin
          state_d = StClear;
          sweep_d = '0;
          sx_d    = '0;
          sy_d    = '0;
        end else if (bus.start) begin
          state_d  = StDraw;
          idx_d    = '0;
          letter_d = bus.letter;
          x0_d     = bus.x0;
          y0_d     = bus.y0;
          fg_d     = bus.fg_colour;
        end
      end
      StDraw: begin
        busy_d = 1'b1;
        x_d    = cell_x[7:0];
        y_d    = cell_y[6:0];
`ifdef GLYPH_BG_EN
        plot_d   = cell_in;
        colour_d = cell_set ? fg_q : BG_COLOUR;
`else
        plot_d   = cell_in && cell_set;
        colour_d = fg_q;
`endif
        idx_d = idx_q + 4'd1;
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end
      end
      StClear: begin
        busy_d   = 1'b1;
        plot_d   = 1'b1;
        colour_d = BG_COLOUR;
        x_d      = sx_q;
        y_d      = sy_q;
        // Counters freeze on the last pixel so the sweep never wraps.
        if (sweep_q == SweepLast) begin
          state_d = StDone;
        end else begin
          sweep_d = sweep_q + 15'd1;
          if (sx_q == SxLast) begin
            sx_d = '0;
            sy_d = sy_q + 7'd1;
          end else begin
            sx_d = sx_q + 8'd1;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      sweep_q  <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      letter_q <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      fg_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sweep_q  <= sweep_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      letter_q <= letter_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      fg_q     <= fg_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
